writeback_ctrl: RTL and testbench
=================================

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, load-return queue entries (power of two, at least 2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 3, consecutive blocked cycles before the queue gets priority.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-005 SHALL have alu_valid  in  1  ALU result offered.
REQ-006 SHALL have alu_ready  out  1  ALU result accepted this cycle.
REQ-007 SHALL have alu_rd  in  5  ALU destination register.
REQ-008 SHALL have alu_data  in  DATA_W  ALU result.
REQ-009 SHALL have ld_valid  in  1  load return offered.
REQ-010 SHALL have ld_ready  out  1  load return accepted this cycle.
REQ-011 SHALL have ld_rd  in  5  load destination register.
REQ-012 SHALL have ld_data  in  DATA_W  load data.
REQ-013 SHALL have rs1 and rs2  in  5 each  decode-stage source registers under query.
REQ-014 SHALL have pend1 and pend2  out  1 each  a write to rs1 or rs2 is still in flight.
REQ-015 SHALL have RegWrite  out  1  register-file write enable.
REQ-016 SHALL have WriteRegister  out  5  register-file write address.
REQ-017 SHALL have WriteData  out  DATA_W  register-file write data.

Function
REQ-018 SHALL complete a transfer on a rising edge when valid and ready are both high; data is ignored otherwise.
REQ-019 SHALL register RegWrite, WriteRegister and WriteData on the rising edge so the register file samples them at the following falling edge.
REQ-020 SHALL issue at most one write per cycle.
REQ-021 SHALL drive an accepted ALU result (alu_rd != 0) on the write port in the next cycle: latency 1.
REQ-022 SHALL enqueue an accepted load (ld_rd != 0) into the FIFO, and drive ld_ready = !full with no same-cycle bypass when full.
REQ-023 SHALL accept a transfer with rd == 0 and discard it, producing no RegWrite and no FIFO entry.
REQ-024 SHALL dequeue the FIFO head to the write port whenever the FIFO is non-empty and the ALU wins no slot; minimum load latency is 2 cycles.
REQ-025 SHALL grant the ALU priority by default.
REQ-026 SHALL run a starve counter that increments each cycle the FIFO is non-empty and not dequeued, and clears on any dequeue or when the FIFO is empty.
REQ-027 SHALL, when the starve counter reaches STARVE_LIMIT, drop alu_ready low for one cycle, dequeue the FIFO in that cycle, and clear the counter.
REQ-028 SHALL let simultaneous enqueue and dequeue on a non-full FIFO both occur, leaving the count unchanged.
REQ-029 SHALL hold alu_ready high in every cycle except the starve-grant cycle, regardless of alu_valid.
REQ-030 SHALL drive pend1 high (combinationally) when rs1 != 0 and rs1 matches any valid FIFO entry or the asserted WriteRegister; pend2 likewise for rs2.
REQ-031 SHALL drive RegWrite low in any cycle with no write issued; WriteRegister and WriteData then hold their last values.
REQ-032 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH, with a separate count/full flag so that full and empty stay distinct.

Reset
REQ-033 SHALL, while reset is high, force RegWrite=0, WriteRegister=0, WriteData=0, FIFO empty, starve counter 0, alu_ready=0, ld_ready=0, pend1=0 and pend2=0.
REQ-034 SHALL assert alu_ready=1 and ld_ready=1 in the first cycle after reset deasserts.
REQ-035 SHALL discard FIFO contents when reset asserts mid-operation, with no partial write issued.

Structure
REQ-036 SHALL take REG_ADDR_W=5, DATA_W, FIFO_DEPTH and STARVE_LIMIT from the shared processor definitions package/include.
REQ-037 SHALL implement the queue as one sub-module, wb_fifo: a synchronous FIFO with count, full and empty flags, and per-entry rd comparison outputs for pend generation.

Verification
REQ-038 SHALL cover: ALU write rd=5, data 0xA5 in cycle N -> RegWrite=1, WriteRegister=5, WriteData=0xA5 in N+1 only.
REQ-039 SHALL cover: load rd=8, data 165, offered with FIFO empty and ALU idle -> enqueued in N, written in N+2; pend1=1 for rs1=8 during N+1..N+2.
REQ-040 SHALL cover: four loads with continuous ALU traffic -> ld_ready=0 after the fourth load; after 3 blocked cycles alu_ready=0 for one cycle and the oldest load is written.
REQ-041 SHALL cover: ALU rd=0 and load rd=0 -> both accepted, RegWrite stays 0, FIFO count unchanged, pend1=0 for rs1=0.
REQ-042 SHALL cover: reset pulse with 3 FIFO entries -> all outputs 0 immediately, FIFO empty after release, and no stale write ever appears.
REQ-043 SHALL cover: enqueue and dequeue in the same cycle at count 2 -> count stays 2, order preserved (rd 3 then 4).

Source files
------------

// File: rtl/writeback_ctrl_pkg.sv
// rtl/writeback_ctrl_pkg.sv - shared processor definitions for the writeback controller
package writeback_ctrl_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int WB_DATA_W       = 32;
    localparam int WB_FIFO_DEPTH   = 4;
    localparam int WB_STARVE_LIMIT = 3;

    // Register 0 is hardwired, so it never counts as a pending destination.
    function automatic logic rd_hit(input logic [REG_ADDR_W-1:0] query,
                                    input logic [REG_ADDR_W-1:0] entry);
        return (query != '0) && (query == entry);
    endfunction

endpackage

// File: rtl/writeback_ctrl_wb_fifo.sv
// rtl/writeback_ctrl_wb_fifo.sv - load-return queue with count/full/empty and per-entry rd match
module wb_fifo
    import writeback_ctrl_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH  = WB_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [REG_ADDR_W-1:0]   wr_rd_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    output logic [REG_ADDR_W-1:0]   head_rd_o,
    output logic [DATA_W-1:0]       head_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    input  logic [REG_ADDR_W-1:0]   q1_rd_i,
    input  logic [REG_ADDR_W-1:0]   q2_rd_i,
    output logic [DEPTH-1:0]        hit1_o,
    output logic [DEPTH-1:0]        hit2_o
);

    localparam int PW = $clog2(DEPTH);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [PW:0]           count_q, count_d;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            rd_mem[wptr_q]   <= wr_rd_i;
            data_mem[wptr_q] <= wr_data_i;
        end
    end

    // Per-entry valid bits let pend lookups ignore stale slots without pointer arithmetic.
    always_comb begin
        vld_d   = vld_q;
        count_d = count_q;
        if (rd_en_i) begin
            vld_d[rptr_q] = 1'b0;
            count_d       = count_d - 1'b1;
        end
        if (wr_en_i) begin
            vld_d[wptr_q] = 1'b1;
            count_d       = count_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (wr_en_i) wptr_q <= wptr_q + 1'b1;
            if (rd_en_i) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    assign head_rd_o   = rd_mem[rptr_q];
    assign head_data_o = data_mem[rptr_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit1_o[i] = vld_q[i] && rd_hit(q1_rd_i, rd_mem[i]);
        assign hit2_o[i] = vld_q[i] && rd_hit(q2_rd_i, rd_mem[i]);
    end

endmodule

// File: rtl/writeback_ctrl.sv
// rtl/writeback_ctrl.sv - arbitrates ALU results and queued load returns onto one register-file write port
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int DATA_W       = WB_DATA_W,
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  pend1,
    output logic                  pend2,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [REG_ADDR_W-1:0]       head_rd;
    logic [DATA_W-1:0]           head_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full, fifo_empty;
    logic [FIFO_DEPTH-1:0]       hit1, hit2;

    logic                  grant, alu_take, ld_take, deq;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0]     wd_q, wd_d;

    wb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en_i     (ld_take),
        .wr_rd_i     (ld_rd),
        .wr_data_i   (ld_data),
        .rd_en_i     (deq),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .q1_rd_i     (rs1),
        .q2_rd_i     (rs2),
        .hit1_o      (hit1),
        .hit2_o      (hit2)
    );

    // The starve grant steals exactly one ALU slot so the oldest load can drain.
    assign grant     = (starve_q == SW'(STARVE_LIMIT)) && (fifo_count != '0);
    assign alu_ready = !reset && !grant;
    assign ld_ready  = !reset && !fifo_full;
    assign alu_take  = alu_valid && alu_ready && (alu_rd != '0);
    assign ld_take   = ld_valid && ld_ready && (ld_rd != '0);
    assign deq       = !fifo_empty && !alu_take;

    always_comb begin
        we_d     = alu_take || deq;
        wa_d     = wa_q;
        wd_d     = wd_q;
        starve_d = '0;
        if (alu_take) begin
            wa_d = alu_rd;
            wd_d = alu_data;
        end else if (deq) begin
            wa_d = head_rd;
            wd_d = head_data;
        end
        if (!fifo_empty && !deq)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            starve_q <= '0;
        end else begin
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            starve_q <= starve_d;
        end
    end

    assign RegWrite      = we_q;
    assign WriteRegister = wa_q;
    assign WriteData     = wd_q;
    assign pend1         = (|hit1) || (we_q && rd_hit(rs1, wa_q));
    assign pend2         = (|hit2) || (we_q && rd_hit(rs2, wa_q));

endmodule

// File: tb/tb_writeback_ctrl.sv
// tb/tb_writeback_ctrl.sv - directed bench for writeback_ctrl with a queue-based reference model
module tb_writeback_ctrl;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_rd = '0, ld_rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic        alu_ready, ld_ready, pend1, pend2, RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    int n_checks = 0;
    int n_fail = 0;

    writeback_ctrl #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1(rs1), .rs2(rs2), .pend1(pend1), .pend2(pend2),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending loads in arrival order, blocked-cycle count, last write.
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    function automatic logic m_alu_ready();
        return !(m_starve >= LIMIT && mq.size() > 0);
    endfunction

    function automatic logic m_pend(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (m_we && m_wa == r) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_starve = 0; m_we = 0; m_wa = '0; m_wd = '0;
        end else begin
            automatic logic alu_wins = alu_valid && m_alu_ready() && alu_rd != 0;
            automatic logic ld_acc = ld_valid && mq.size() < DEPTH && ld_rd != 0;
            automatic ent_t e;
            if (alu_wins) begin
                m_we = 1; m_wa = alu_rd; m_wd = alu_data;
                m_starve = (mq.size() > 0) ? m_starve + 1 : 0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = 1; m_wa = e.rd; m_wd = e.data;
                m_starve = 0;
            end else begin
                m_we = 0; m_starve = 0;
            end
            if (ld_acc) begin
                e.rd = ld_rd; e.data = ld_data;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_alu_ready", alu_ready, 0);
            chk("rst_ld_ready", ld_ready, 0);
            chk("rst_regwrite", RegWrite, 0);
            chk("rst_wreg", WriteRegister, 0);
            chk("rst_wdata", WriteData, 0);
        end else begin
            chk("m_alu_ready", alu_ready, m_alu_ready());
            chk("m_ld_ready", ld_ready, mq.size() < DEPTH);
            chk("m_regwrite", RegWrite, m_we);
            chk("m_wreg", WriteRegister, m_wa);
            chk("m_wdata", WriteData, m_wd);
            chk("m_pend1", pend1, m_pend(rs1));
            chk("m_pend2", pend2, m_pend(rs2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; ld_valid = 0;
    endtask

    initial begin
        @(negedge clk);
        chk("reset_alu_ready", alu_ready, 0);
        chk("reset_pend1", pend1, 0);
        step();
        reset = 0;
        @(negedge clk);
        chk("post_reset_alu_ready", alu_ready, 1);
        chk("post_reset_ld_ready", ld_ready, 1);

        // ALU write rd=5 data=0xA5: visible exactly one cycle later.
        step();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hA5;
        step(); idle();
        @(negedge clk);
        chk("alu_we", RegWrite, 1);
        chk("alu_wreg", WriteRegister, 5);
        chk("alu_wdata", WriteData, 32'hA5);
        step();
        @(negedge clk);
        chk("alu_we_once", RegWrite, 0);
        chk("alu_wreg_hold", WriteRegister, 5);

        // Load rd=8 data=165 with ALU idle: written two cycles later, pending meanwhile.
        step();
        ld_valid = 1; ld_rd = 8; ld_data = 165; rs1 = 8;
        @(negedge clk);
        chk("ld_ready_empty", ld_ready, 1);
        step(); idle();
        @(negedge clk);
        chk("ld_pend_n1", pend1, 1);
        chk("ld_we_n1", RegWrite, 0);
        step();
        @(negedge clk);
        chk("ld_we_n2", RegWrite, 1);
        chk("ld_wreg_n2", WriteRegister, 8);
        chk("ld_wdata_n2", WriteData, 165);
        chk("ld_pend_n2", pend1, 1);
        step();
        @(negedge clk);
        chk("ld_pend_n3", pend1, 0);

        // Four loads under continuous ALU traffic, then a starve grant.
        for (int i = 0; i < 4; i++) begin
            step();
            alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 200 + i;
            ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 100 + i;
        end
        step();
        ld_valid = 0; alu_rd = 24; alu_data = 204;
        @(negedge clk);
        chk("starve_alu_ready", alu_ready, 0);
        chk("full_ld_ready", ld_ready, 0);
        chk("starve_prev_wreg", WriteRegister, 23);
        step();
        @(negedge clk);
        chk("starve_wreg", WriteRegister, 10);
        chk("starve_wdata", WriteData, 100);
        chk("starve_alu_back", alu_ready, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            alu_rd = 5'(25 + i); alu_data = 205 + i;
        end
        step(); idle();
        repeat (6) step();

        // rd=0 transfers are accepted and discarded.
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        ld_valid = 1; ld_rd = 0; ld_data = 32'h5678; rs1 = 0;
        @(negedge clk);
        chk("rd0_alu_ready", alu_ready, 1);
        chk("rd0_ld_ready", ld_ready, 1);
        step(); idle();
        @(negedge clk);
        chk("rd0_we", RegWrite, 0);
        chk("rd0_pend1", pend1, 0);
        step();
        @(negedge clk);
        chk("rd0_we_later", RegWrite, 0);

        // Enqueue and dequeue together at count 2 keep order 3,4,5.
        step();
        alu_valid = 1; alu_rd = 30; alu_data = 300; ld_valid = 1; ld_rd = 3; ld_data = 33;
        step();
        alu_rd = 31; alu_data = 301; ld_rd = 4; ld_data = 44;
        step();
        alu_valid = 0; ld_rd = 5; ld_data = 55;
        @(negedge clk);
        chk("sim_wreg_31", WriteRegister, 31);
        step(); idle();
        @(negedge clk);
        chk("sim_wreg_3", WriteRegister, 3);
        step();
        @(negedge clk);
        chk("sim_wreg_4", WriteRegister, 4);
        chk("sim_wdata_4", WriteData, 44);
        step();
        @(negedge clk);
        chk("sim_wreg_5", WriteRegister, 5);
        step();

        // Reset mid-operation with three queued loads.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(21 + i); alu_data = 210 + i;
            ld_valid = 1; ld_rd = 5'(11 + i); ld_data = 110 + i;
            step();
        end
        ld_valid = 0; alu_rd = 24; rs1 = 11; rs2 = 23;
        #1;
        chk("pre_rst_pend1", pend1, 1);
        chk("pre_rst_pend2", pend2, 1);
        reset = 1; idle();
        #1;
        chk("mid_rst_alu_ready", alu_ready, 0);
        chk("mid_rst_ld_ready", ld_ready, 0);
        chk("mid_rst_we", RegWrite, 0);
        chk("mid_rst_wreg", WriteRegister, 0);
        chk("mid_rst_wdata", WriteData, 0);
        chk("mid_rst_pend1", pend1, 0);
        chk("mid_rst_pend2", pend2, 0);
        step();
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_write", RegWrite, 0);
            chk("post_rst_empty", ld_ready, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
